mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: if_req  in  1  fetch request, held until if_done; if_addr  in  16  fetch address (PC).
REQ-004 SHALL have ports: if_done  out  1  one-cycle strobe, fetch complete; if_inst  out  16  fetched word, held until next fetch completes.
REQ-005 SHALL have ports: mem_req  in  1  data request, held until mem_done; mem_we  in  1  1 = write, 0 = read; mem_addr  in  16; mem_wdata  in  16.
REQ-006 SHALL have ports: mem_done  out  1  one-cycle completion strobe; mem_rdata  out  16  read word, held until next data read completes.
REQ-007 SHALL have ports: mem_conflict  out  1  tells fetch stage to stall and insert NOP.
REQ-008 SHALL have ports: ram_addr  out  16; ram_wdata  out  16; ram_rdata  in  16; ram_ce_n, ram_oe_n, ram_we_n  out  1 each, active-low strobes.

Function
REQ-009 SHALL implement FSM states IDLE, IF_RD, MEM_RD, WR_SETUP, WR_PULSE.
REQ-010 IDLE: if mem_req=1 -> MEM_RD (mem_we=0) or WR_SETUP (mem_we=1); else if if_req=1 -> IF_RD; else stay IDLE.
REQ-011 Data port SHALL have priority over fetch when both requests are high in IDLE, subject to REQ-022.
REQ-012 IF_RD/MEM_RD: ram_ce_n=0, ram_oe_n=0, ram_we_n=1, ram_addr = requester address; the done strobe is high this cycle; ram_rdata is captured into if_inst/mem_rdata on the closing edge; next state IDLE.
REQ-013 WR_SETUP: ram_ce_n=0, ram_oe_n=1, ram_we_n=1, ram_addr/ram_wdata driven; next state WR_PULSE.
REQ-014 WR_PULSE: same as WR_SETUP but ram_we_n=0; mem_done high; next state IDLE.
REQ-015 Addresses and data SHALL be registered on entry to an access state and held constant for its whole duration.
REQ-016 Latency from request sampled in IDLE: read done 1 cycle later, data valid on outputs from 2 cycles later; write done 2 cycles later.
REQ-017 Every access SHALL return through IDLE, with one idle cycle minimum between accesses; requester deasserts req at the edge closing its done cycle.
REQ-018 In IDLE, all ram strobes SHALL be 1 and ram_addr/ram_wdata SHALL hold their last value.
REQ-019 mem_conflict SHALL be combinational: 1 when state is MEM_RD/WR_SETUP/WR_PULSE, or when state is IDLE and mem_req=1 and mem_req wins arbitration.
REQ-020 A request deasserted before its done strobe SHALL be a protocol violation; the access in flight SHALL still complete unchanged.

Reset
REQ-021 While rst=0 (asynchronous): state=IDLE; ram_ce_n=ram_oe_n=ram_we_n=1; ram_addr=ram_wdata=0; if_done=mem_done=0; if_inst=16'h0800 (NOP); mem_rdata=0; starvation counter=0. A write aborted mid-pulse SHALL release ram_we_n immediately.

Configuration
REQ-022 With MEM_ARB_STARVE_GUARD_EN defined: count consecutive data grants made while if_req=1, and clear the count on a fetch grant. When the count equals STARVE_LIMIT (4), the next IDLE decision SHALL grant fetch even if mem_req=1, with mem_conflict=0 that cycle.
REQ-023 Without MEM_ARB_STARVE_GUARD_EN: strict data priority, with no counter logic synthesized.

Structure
REQ-024 Package mem_arb_pkg SHALL hold the state enum, NOP_INST=16'h0800, and STARVE_LIMIT=4.
REQ-025 The starvation counter SHALL be sub-module arb_starve_counter, instantiated only under MEM_ARB_STARVE_GUARD_EN; the FSM stays in mem_arbiter.

Verification
REQ-026 Fetch only: if_req=1, if_addr=0x0004, ram_rdata=0x4A05 -> if_done in cycle 2, ram_oe_n=0 in cycle 2 only, if_inst=0x4A05 from cycle 3.
REQ-027 Write: mem_req=1, mem_we=1, addr=0x0004, wdata=0x001A -> ram_we_n=0 exactly one cycle (WR_PULSE), with addr/data stable across WR_SETUP and WR_PULSE; mem_done in cycle 3.
REQ-028 Collision: if_req and mem_req (read 0x0010) both rise together -> MEM_RD first with mem_conflict=1, then IDLE, then IF_RD; if_done follows mem_done by 2 cycles.
REQ-029 Reset mid-write: rst=0 during WR_PULSE -> ram_we_n=1 in the same cycle, state=IDLE, if_inst=0x0800; after release, no done strobe is produced.
REQ-030 With MEM_ARB_STARVE_GUARD_EN: mem_req held high continuously with if_req=1 -> exactly 4 data grants, then 1 fetch grant, repeating. Without the macro -> fetch never granted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction-fetch / data-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IF_RD,
    MEM_RD,
    WR_SETUP,
    WR_PULSE
  } arb_state_t;

  localparam logic [15:0] NOP_INST     = 16'h0800;
  localparam int          STARVE_LIMIT = 4;
  localparam int          STARVE_W     = $clog2(STARVE_LIMIT + 1);

endpackage

// File: rtl/arb_starve_counter.sv
// Counts back-to-back data grants made while a fetch is waiting.
// Only instantiated when MEM_ARB_STARVE_GUARD_EN is defined.
module arb_starve_counter
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic data_grant,
  input  logic fetch_grant,
  input  logic if_req,
  output logic starve_hit
);

  logic [STARVE_W-1:0] cnt;

  // A data grant with no fetch pending breaks the starvation run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (fetch_grant || (data_grant && !if_req)) begin
      cnt <= '0;
    end else if (data_grant && (cnt != STARVE_W'(STARVE_LIMIT))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign starve_hit = (cnt == STARVE_W'(STARVE_LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port async SRAM arbiter between instruction fetch and data port.
// Optional fetch starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_conflict,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  arb_state_t state, state_nxt;
  logic       starve_hit;
  logic       data_wins;
  logic       data_grant;
  logic       fetch_grant;

`ifdef MEM_ARB_STARVE_GUARD_EN
  arb_starve_counter u_starve (
    .clk        (clk),
    .rst        (rst),
    .data_grant (data_grant),
    .fetch_grant(fetch_grant),
    .if_req     (if_req),
    .starve_hit (starve_hit)
  );
`else
  assign starve_hit = 1'b0;
`endif

  // Starvation only overrides data priority when a fetch is actually waiting.
  assign data_wins   = mem_req && !(starve_hit && if_req);
  assign data_grant  = (state == IDLE) && data_wins;
  assign fetch_grant = (state == IDLE) && !data_wins && if_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    ram_ce_n     = 1'b1;
    ram_oe_n     = 1'b1;
    ram_we_n     = 1'b1;
    if_done      = 1'b0;
    mem_done     = 1'b0;
    mem_conflict = 1'b0;
    case (state)
      IDLE: begin
        mem_conflict = data_wins;
        if (data_wins)   state_nxt = mem_we ? WR_SETUP : MEM_RD;
        else if (if_req) state_nxt = IF_RD;
      end
      IF_RD: begin
        ram_ce_n  = 1'b0;
        ram_oe_n  = 1'b0;
        if_done   = 1'b1;
        state_nxt = IDLE;
      end
      MEM_RD: begin
        ram_ce_n     = 1'b0;
        ram_oe_n     = 1'b0;
        mem_done     = 1'b1;
        mem_conflict = 1'b1;
        state_nxt    = IDLE;
      end
      WR_SETUP: begin
        ram_ce_n     = 1'b0;
        mem_conflict = 1'b1;
        state_nxt    = WR_PULSE;
      end
      WR_PULSE: begin
        ram_ce_n     = 1'b0;
        ram_we_n     = 1'b0;
        mem_done     = 1'b1;
        mem_conflict = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address/data latched at grant so the SRAM sees stable values for the whole access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_inst   <= DATA_W'(NOP_INST);
      mem_rdata <= '0;
    end else begin
      if (data_grant) begin
        ram_addr <= mem_addr;
        if (mem_we) ram_wdata <= mem_wdata;
      end else if (fetch_grant) begin
        ram_addr <= if_addr;
      end
      if (state == IF_RD)  if_inst   <= ram_rdata;
      if (state == MEM_RD) mem_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transactions plus collision,
// reset-during-write and sustained-contention sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_done;
  logic [15:0] if_inst;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_done;
  logic [15:0] mem_rdata;
  logic        mem_conflict;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic        ram_ce_n;
  logic        ram_oe_n;
  logic        ram_we_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_done     (if_done),
    .if_inst     (if_inst),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_done    (mem_done),
    .mem_rdata   (mem_rdata),
    .mem_conflict(mem_conflict),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .ram_ce_n    (ram_ce_n),
    .ram_oe_n    (ram_oe_n),
    .ram_we_n    (ram_we_n)
  );

  typedef struct {
    logic        fetch;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        exp_conflict;
    logic [15:0] exp_result;
  } vec_t;

  vec_t vecs[6];
  logic [15:0] exp_inst;
  logic [15:0] exp_rdata;
  logic [15:0] exp_addr;
  logic [15:0] exp_wdata;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_strobes(input string name, input logic ce, input logic oe, input logic we);
    chk({name, ".ce_n"}, {15'd0, ram_ce_n}, {15'd0, ce});
    chk({name, ".oe_n"}, {15'd0, ram_oe_n}, {15'd0, oe});
    chk({name, ".we_n"}, {15'd0, ram_we_n}, {15'd0, we});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    string n;
    n = $sformatf("v%0d", i);
    ram_rdata = v.rdata;
    if (v.fetch) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr; mem_wdata = v.wdata;
    end
    @(negedge clk);
    chk({n, ".idle_conflict"}, {15'd0, mem_conflict}, {15'd0, v.exp_conflict});
    step();
    if (v.we) begin
      @(negedge clk);
      chk_strobes({n, ".setup"}, 1'b0, 1'b1, 1'b1);
      chk({n, ".setup_done"}, {15'd0, mem_done}, 16'd0);
      chk({n, ".setup_addr"}, ram_addr, v.addr);
      chk({n, ".setup_wdata"}, ram_wdata, v.wdata);
      step();
      @(negedge clk);
      chk_strobes({n, ".pulse"}, 1'b0, 1'b1, 1'b0);
      chk({n, ".pulse_done"}, {15'd0, mem_done}, 16'd1);
      chk({n, ".pulse_addr"}, ram_addr, v.addr);
      chk({n, ".pulse_wdata"}, ram_wdata, v.wdata);
      exp_wdata = v.wdata;
    end else begin
      @(negedge clk);
      chk_strobes({n, ".read"}, 1'b0, 1'b0, 1'b1);
      chk({n, ".read_addr"}, ram_addr, v.addr);
      chk({n, ".if_done"}, {15'd0, if_done}, {15'd0, v.fetch});
      chk({n, ".mem_done"}, {15'd0, mem_done}, {15'd0, !v.fetch});
      if (v.fetch) exp_inst = v.exp_result;
      else         exp_rdata = v.exp_result;
    end
    exp_addr = v.addr;
    step();
    if_req = 1'b0; mem_req = 1'b0;
    ram_rdata = 16'hDEAD;
    @(negedge clk);
    chk_strobes({n, ".idle"}, 1'b1, 1'b1, 1'b1);
    chk({n, ".idle_done"}, {14'd0, if_done, mem_done}, 16'd0);
    chk({n, ".if_inst"}, if_inst, exp_inst);
    chk({n, ".mem_rdata"}, mem_rdata, exp_rdata);
    chk({n, ".hold_addr"}, ram_addr, exp_addr);
    chk({n, ".hold_wdata"}, ram_wdata, exp_wdata);
    step();
  endtask

  initial begin
    int grants;
    int fetches;
    int cyc;
    logic [15:0] exp_c;
    bit guard;
`ifdef MEM_ARB_STARVE_GUARD_EN
    guard = 1'b1;
`else
    guard = 1'b0;
`endif
    //           fetch we  addr      wdata     rdata     conf  result
    vecs[0] = '{1'b1, 1'b0, 16'h0004, 16'h0000, 16'h4A05, 1'b0, 16'h4A05};
    vecs[1] = '{1'b0, 1'b1, 16'h0004, 16'h001A, 16'h0000, 1'b1, 16'h0000};
    vecs[2] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b1, 16'hBEEF};
    vecs[3] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 16'h0000};
    vecs[4] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 16'hFFFF};
    vecs[5] = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 16'h0000};

    rst = 1'b0; if_req = 1'b0; if_addr = 16'h0; mem_req = 1'b0; mem_we = 1'b0;
    mem_addr = 16'h0; mem_wdata = 16'h0; ram_rdata = 16'h0;
    repeat (2) @(negedge clk);
    chk_strobes("rst", 1'b1, 1'b1, 1'b1);
    chk("rst.addr", ram_addr, 16'h0000);
    chk("rst.wdata", ram_wdata, 16'h0000);
    chk("rst.done", {14'd0, if_done, mem_done}, 16'd0);
    chk("rst.if_inst", if_inst, 16'h0800);
    chk("rst.mem_rdata", mem_rdata, 16'h0000);
    chk("rst.conflict", {15'd0, mem_conflict}, 16'd0);
    rst = 1'b1;
    exp_inst = 16'h0800; exp_rdata = 16'h0; exp_addr = 16'h0; exp_wdata = 16'h0;
    step();

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Collision: data wins, one idle cycle, then the fetch
    if_req = 1'b1; if_addr = 16'h0020;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0010; ram_rdata = 16'h1234;
    @(negedge clk);
    chk("col.idle_conflict", {15'd0, mem_conflict}, 16'd1);
    step();
    @(negedge clk);
    chk("col.mem_done", {14'd0, if_done, mem_done}, 16'd1);
    chk("col.rd_conflict", {15'd0, mem_conflict}, 16'd1);
    chk("col.rd_addr", ram_addr, 16'h0010);
    step();
    mem_req = 1'b0; ram_rdata = 16'h5678;
    @(negedge clk);
    chk("col.gap_done", {14'd0, if_done, mem_done}, 16'd0);
    chk("col.gap_conflict", {15'd0, mem_conflict}, 16'd0);
    chk("col.mem_rdata", mem_rdata, 16'h1234);
    step();
    @(negedge clk);
    chk("col.if_done", {14'd0, if_done, mem_done}, 16'd2);
    chk("col.if_addr", ram_addr, 16'h0020);
    chk_strobes("col.if_rd", 1'b0, 1'b0, 1'b1);
    step();
    if_req = 1'b0;
    @(negedge clk);
    chk("col.if_inst", if_inst, 16'h5678);
    step();

    // Reset asserted while the write pulse is active
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0033; mem_wdata = 16'h0044;
    step(); step();
    @(negedge clk);
    chk("rw.pulse_we", {15'd0, ram_we_n}, 16'd0);
    #1 rst = 1'b0;
    #1;
    chk("rw.we_release", {15'd0, ram_we_n}, 16'd1);
    chk("rw.done", {14'd0, if_done, mem_done}, 16'd0);
    chk("rw.if_inst", if_inst, 16'h0800);
    chk("rw.addr", ram_addr, 16'h0000);
    mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rw.post_done%0d", k), {14'd0, if_done, mem_done}, 16'd0);
      chk($sformatf("rw.post_ce%0d", k), {15'd0, ram_ce_n}, 16'd1);
    end
    step();

    // Sustained contention: data held high with a fetch waiting
    if_req = 1'b1; if_addr = 16'h0100;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0200; ram_rdata = 16'h0;
    grants = 0; fetches = 0; cyc = 0;
    while (grants < 20 && cyc < 100) begin
      @(negedge clk);
      if (if_done || mem_done) begin
        exp_c = (guard && (grants % 5 == 4)) ? 16'd2 : 16'd1;
        chk($sformatf("sv.grant%0d", grants), {14'd0, if_done, mem_done}, exp_c);
        if (if_done) fetches++;
        grants++;
      end else if (ram_ce_n) begin
        exp_c = (guard && (grants % 5 == 4)) ? 16'd0 : 16'd1;
        chk($sformatf("sv.conflict%0d", grants), {15'd0, mem_conflict}, exp_c);
      end
      cyc++;
    end
    chk("sv.grant_count", 16'(grants), 16'd20);
    chk("sv.fetch_count", 16'(fetches), guard ? 16'd4 : 16'd0);
    step();
    if_req = 1'b0; mem_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
